// File: rtl/aes_stream_requester.sv
// AES stream requester: turns a packet request (command + N plaintext
// blocks) into an AXIS word stream toward the AES engine. It repacks the
// engine's 32-bit response words into 128-bit result blocks and checks
// that the engine's tlast lines up with the expected packet length.
module aes_stream_requester #(
    parameter int BLK_CNT_WIDTH = 9
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [31:0]              req_cmd,
    input  logic [BLK_CNT_WIDTH-1:0] req_blk_cnt_m1,
    input  logic                     src_valid,
    output logic                     src_ready,
    input  logic [127:0]             src_data,
    output logic                     m_axis_tvalid,
    output logic [31:0]              m_axis_tdata,
    output logic [3:0]               m_axis_tstrb,
    output logic                     m_axis_tlast,
    input  logic                     m_axis_tready,
    input  logic                     s_axis_tvalid,
    input  logic [31:0]              s_axis_tdata,
    input  logic                     s_axis_tlast,
    output logic                     s_axis_tready,
    output logic                     res_valid,
    output logic [127:0]             res_data,
    input  logic                     res_ready,
    output logic                     busy,
    output logic                     done,
    output logic                     err_len
);

    // One extra bit so that a full 2^BLK_CNT_WIDTH block count never wraps
    localparam int CW = BLK_CNT_WIDTH + 1;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_SEND_CMD   = 3'd1,
        ST_LOAD_BLK   = 3'd2,
        ST_SEND_WORDS = 3'd3,
        ST_WAIT_RX    = 3'd4
    } tx_state_t;

    tx_state_t       state_r, state_next_s;
    logic [31:0]     cmd_r;
    logic [CW-1:0]   cnt_r;
    logic [CW-1:0]   tx_blk_r;
    logic [1:0]      tx_word_r;
    logic [127:0]    tx_shift_r;
    logic [95:0]     rx_shift_r;
    logic [1:0]      rx_word_r;
    logic [CW-1:0]   rx_blk_r;
    logic            res_valid_r;
    logic [127:0]    res_data_r;
    logic            rx_last_r;   // result block being held is the packet's last
    logic            rx_fin_r;    // last result delivered, waiting for TX to finish
    logic            done_r;
    logic            err_r;

    logic            req_ready_s, src_ready_s;
    logic            m_tvalid_s, m_tlast_s;
    logic [31:0]     m_tdata_s;
    logic            s_tready_s, s_hs_s, m_hs_s, res_hs_s;
    logic            rx_final_beat_s, tx_last_blk_s;
    logic            err_s, fin_evt_s, done_s;

    assign s_tready_s      = (state_r != ST_IDLE) && !res_valid_r;
    assign s_hs_s          = s_axis_tvalid && s_tready_s;
    assign m_hs_s          = m_tvalid_s && m_axis_tready;
    assign res_hs_s        = res_valid_r && res_ready;
    assign rx_final_beat_s = (rx_word_r == 2'd3) && (rx_blk_r == cnt_r);
    assign tx_last_blk_s   = (tx_blk_r == cnt_r);
    // Any tlast disagreement with the expected packet length is fatal to the packet
    assign err_s           = s_hs_s && (s_axis_tlast != rx_final_beat_s);
    assign fin_evt_s       = rx_fin_r || (res_hs_s && rx_last_r);
    // Completion waits until TX has finished sending as well
    assign done_s          = fin_evt_s && (state_r == ST_WAIT_RX);

    // TX state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // TX next-state and Moore-style handshake outputs
    always_comb begin
        state_next_s = state_r;
        req_ready_s  = 1'b0;
        src_ready_s  = 1'b0;
        m_tvalid_s   = 1'b0;
        m_tdata_s    = 32'd0;
        m_tlast_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                req_ready_s = 1'b1;
                if (req_valid) begin
                    state_next_s = ST_SEND_CMD;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SEND_CMD: begin
                m_tvalid_s = 1'b1;
                m_tdata_s  = cmd_r;
                if (m_axis_tready) begin
                    state_next_s = ST_LOAD_BLK;
                end else begin
                    state_next_s = ST_SEND_CMD;
                end
            end
            ST_LOAD_BLK: begin
                src_ready_s = 1'b1;
                if (src_valid) begin
                    state_next_s = ST_SEND_WORDS;
                end else begin
                    state_next_s = ST_LOAD_BLK;
                end
            end
            ST_SEND_WORDS: begin
                m_tvalid_s = 1'b1;
                m_tdata_s  = tx_shift_r[127:96];
                m_tlast_s  = (tx_word_r == 2'd3) && tx_last_blk_s;
                if (m_hs_s && (tx_word_r == 2'd3)) begin
                    if (tx_last_blk_s) begin
                        state_next_s = ST_WAIT_RX;
                    end else begin
                        state_next_s = ST_LOAD_BLK;
                    end
                end else begin
                    state_next_s = ST_SEND_WORDS;
                end
            end
            ST_WAIT_RX: begin
                state_next_s = ST_WAIT_RX;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
        // Completion or a length error ends the packet from any state
        if (err_s || done_s) begin
            state_next_s = ST_IDLE;
        end else begin
            state_next_s = state_next_s;
        end
    end

    // TX datapath: latched request, block shift register and counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmd_r      <= 32'd0;
            cnt_r      <= '0;
            tx_blk_r   <= '0;
            tx_word_r  <= 2'd0;
            tx_shift_r <= 128'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_valid) begin
                        cmd_r     <= req_cmd;
                        cnt_r     <= {1'b0, req_blk_cnt_m1};
                        tx_blk_r  <= '0;
                        tx_word_r <= 2'd0;
                    end
                end
                ST_LOAD_BLK: begin
                    if (src_valid) begin
                        tx_shift_r <= src_data;
                        tx_word_r  <= 2'd0;
                    end
                end
                ST_SEND_WORDS: begin
                    if (m_hs_s) begin
                        tx_shift_r <= {tx_shift_r[95:0], 32'd0};
                        tx_word_r  <= tx_word_r + 2'd1;
                        if ((tx_word_r == 2'd3) && !tx_last_blk_s) begin
                            tx_blk_r <= tx_blk_r + CW'(1);
                        end
                    end
                end
                default: begin
                    tx_word_r <= tx_word_r;
                end
            endcase
        end
    end

    // RX path: pack engine words into result blocks and track packet end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_shift_r  <= 96'd0;
            rx_word_r   <= 2'd0;
            rx_blk_r    <= '0;
            res_valid_r <= 1'b0;
            res_data_r  <= 128'd0;
            rx_last_r   <= 1'b0;
            rx_fin_r    <= 1'b0;
        end else if (err_s || done_s) begin
            rx_word_r   <= 2'd0;
            rx_blk_r    <= '0;
            res_valid_r <= 1'b0;
            rx_last_r   <= 1'b0;
            rx_fin_r    <= 1'b0;
        end else if (s_hs_s) begin
            rx_shift_r <= {rx_shift_r[63:0], s_axis_tdata};
            rx_word_r  <= rx_word_r + 2'd1;
            if (rx_word_r == 2'd3) begin
                res_valid_r <= 1'b1;
                res_data_r  <= {rx_shift_r, s_axis_tdata};
                rx_blk_r    <= rx_blk_r + CW'(1);
                rx_last_r   <= rx_final_beat_s;
            end
        end else if (res_hs_s) begin
            res_valid_r <= 1'b0;
            if (rx_last_r) begin
                rx_last_r <= 1'b0;
                rx_fin_r  <= 1'b1;
            end
        end
    end

    // Registered one-cycle status pulses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done_r <= 1'b0;
            err_r  <= 1'b0;
        end else begin
            done_r <= done_s || err_s;
            err_r  <= err_s;
        end
    end

    assign req_ready     = req_ready_s;
    assign src_ready     = src_ready_s;
    assign m_axis_tvalid = m_tvalid_s;
    assign m_axis_tdata  = m_tdata_s;
    assign m_axis_tstrb  = 4'hF;
    assign m_axis_tlast  = m_tlast_s;
    assign s_axis_tready = s_tready_s;
    assign res_valid     = res_valid_r;
    assign res_data      = res_data_r;
    assign busy          = (state_r != ST_IDLE);
    assign done          = done_r;
    assign err_len       = err_r;

endmodule
